// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, requester IDs and
// tag FIFO sizing defaults.
package sdram_arb_pkg;

    localparam int TAG_DEPTH_DEF = 4;
    localparam int TAG_AW        = $clog2(TAG_DEPTH_DEF);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    typedef enum logic {
        SRC_VID = 1'b0,
        SRC_CPU = 1'b1
    } src_t;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// In-order tag FIFO: remembers which requester issued each outstanding read
// so responses can be steered back without any ID on the memory side.
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = TAG_DEPTH_DEF
) (
    input  logic clk,
    input  logic reset_n_i,
    input  logic push,
    input  src_t push_src,
    input  logic pop,
    output src_t head_src,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    src_t          mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Guard both ends so an illegal push or pop never corrupts the pointers.
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign head_src  = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= SRC_VID;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_src;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller command port between video scan-out (priority)
// and the CPU, with a video run-length limit and tag-based read routing.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 32,
    parameter int TAG_DEPTH   = TAG_DEPTH_DEF,
    parameter int VID_RUN_MAX = 8
) (
    input  logic                clk,
    input  logic                reset_n_i,
    input  logic                vid_req_i,
    input  logic [ADDR_W-1:0]   vid_addr_i,
    output logic                vid_gnt_o,
    output logic                vid_rvalid_o,
    output logic [DATA_W-1:0]   vid_rdata_o,
    input  logic                cpu_req_i,
    input  logic                cpu_we_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_wdata_i,
    input  logic [DATA_W/8-1:0] cpu_wmask_i,
    output logic                cpu_gnt_o,
    output logic                cpu_rvalid_o,
    output logic [DATA_W-1:0]   cpu_rdata_o,
    output logic                mem_valid_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_ready_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                err_o
);

    localparam int MASK_W = DATA_W / 8;
    localparam int RUN_W  = $clog2(VID_RUN_MAX + 1);

    state_t             state_r;
    src_t               win_r;
    logic [RUN_W-1:0]   vid_run_r;
    logic               mem_valid_r;
    logic               mem_we_r;
    logic [ADDR_W-1:0]  mem_addr_r;
    logic [DATA_W-1:0]  mem_wdata_r;
    logic [MASK_W-1:0]  mem_wmask_r;
    logic               vid_rvalid_r;
    logic               cpu_rvalid_r;
    logic [DATA_W-1:0]  vid_rdata_r;
    logic [DATA_W-1:0]  cpu_rdata_r;
    logic               err_r;

    logic               vid_elig_s;
    logic               cpu_elig_s;
    logic               cpu_win_s;
    logic               accept_s;
    logic               tag_push_s;
    logic               rsp_hit_s;
    logic               tag_full_s;
    logic               tag_empty_s;
    src_t               tag_head_s;

    assign accept_s   = (state_r == ISSUE) && mem_ready_i;
    assign tag_push_s = accept_s && !mem_we_r;
    assign rsp_hit_s  = mem_rvalid_i && !tag_empty_s;

    sdram_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .push      (tag_push_s),
        .push_src  (win_r),
        .pop       (rsp_hit_s),
        .head_src  (tag_head_s),
        .full      (tag_full_s),
        .empty     (tag_empty_s)
    );

    // Winner selection; reads need a free tag slot, writes never do.
    always_comb begin
        vid_elig_s = 1'b0;
        cpu_elig_s = 1'b0;
        cpu_win_s  = 1'b0;
        if (state_r == IDLE) begin
            vid_elig_s = vid_req_i && !tag_full_s;
            cpu_elig_s = cpu_req_i && (cpu_we_i || !tag_full_s);
            cpu_win_s  = cpu_elig_s &&
                         (!vid_elig_s || (vid_run_r == RUN_W'(VID_RUN_MAX)));
        end else begin
            vid_elig_s = 1'b0;
            cpu_elig_s = 1'b0;
            cpu_win_s  = 1'b0;
        end
    end

    // Arbitration FSM, command register and video run-length counter.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= IDLE;
            win_r       <= SRC_VID;
            vid_run_r   <= '0;
            mem_valid_r <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_wmask_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!cpu_req_i) begin
                        vid_run_r <= '0;
                    end
                    if (cpu_win_s) begin
                        state_r     <= ISSUE;
                        win_r       <= SRC_CPU;
                        mem_valid_r <= 1'b1;
                        mem_we_r    <= cpu_we_i;
                        mem_addr_r  <= cpu_addr_i;
                        mem_wdata_r <= cpu_wdata_i;
                        mem_wmask_r <= cpu_wmask_i;
                    end else if (vid_elig_s) begin
                        state_r     <= ISSUE;
                        win_r       <= SRC_VID;
                        mem_valid_r <= 1'b1;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= vid_addr_i;
                        mem_wdata_r <= '0;
                        mem_wmask_r <= '0;
                    end
                end
                ISSUE: begin
                    if (mem_ready_i) begin
                        state_r     <= IDLE;
                        mem_valid_r <= 1'b0;
                        if (win_r == SRC_CPU) begin
                            vid_run_r <= '0;
                        end else if (vid_run_r != RUN_W'(VID_RUN_MAX)) begin
                            vid_run_r <= vid_run_r + RUN_W'(1);
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    mem_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Response steering; a response with no outstanding tag is dropped and flagged.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            vid_rvalid_r <= 1'b0;
            cpu_rvalid_r <= 1'b0;
            vid_rdata_r  <= '0;
            cpu_rdata_r  <= '0;
            err_r        <= 1'b0;
        end else begin
            vid_rvalid_r <= rsp_hit_s && (tag_head_s == SRC_VID);
            cpu_rvalid_r <= rsp_hit_s && (tag_head_s == SRC_CPU);
            if (rsp_hit_s && (tag_head_s == SRC_VID)) begin
                vid_rdata_r <= mem_rdata_i;
            end
            if (rsp_hit_s && (tag_head_s == SRC_CPU)) begin
                cpu_rdata_r <= mem_rdata_i;
            end
            if (mem_rvalid_i && tag_empty_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign vid_gnt_o    = accept_s && (win_r == SRC_VID);
    assign cpu_gnt_o    = accept_s && (win_r == SRC_CPU);
    assign mem_valid_o  = mem_valid_r;
    assign mem_we_o     = mem_we_r;
    assign mem_addr_o   = mem_addr_r;
    assign mem_wdata_o  = mem_wdata_r;
    assign mem_wmask_o  = mem_wmask_r;
    assign vid_rvalid_o = vid_rvalid_r;
    assign vid_rdata_o  = vid_rdata_r;
    assign cpu_rvalid_o = cpu_rvalid_r;
    assign cpu_rdata_o  = cpu_rdata_r;
    assign err_o        = err_r;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized scoreboard bench for sdram_port_arbiter: a queue-based model
// predicts commands and routed read data; a negedge monitor compares.
module tb_sdram_port_arbiter;

    localparam int ADDR_W      = 24;
    localparam int DATA_W      = 32;
    localparam int MASK_W      = DATA_W / 8;
    localparam int TAG_DEPTH   = 4;
    localparam int VID_RUN_MAX = 8;

    typedef struct {
        logic              src;  // 0 video, 1 cpu
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } cmd_t;

    logic              clk;
    logic              reset_n_i;
    logic              vid_req_i;
    logic [ADDR_W-1:0] vid_addr_i;
    logic              vid_gnt_o;
    logic              vid_rvalid_o;
    logic [DATA_W-1:0] vid_rdata_o;
    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_wdata_i;
    logic [MASK_W-1:0] cpu_wmask_i;
    logic              cpu_gnt_o;
    logic              cpu_rvalid_o;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              mem_valid_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [MASK_W-1:0] mem_wmask_o;
    logic              mem_ready_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              err_o;

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH), .VID_RUN_MAX(VID_RUN_MAX)
    ) dut (
        .clk(clk), .reset_n_i(reset_n_i),
        .vid_req_i(vid_req_i), .vid_addr_i(vid_addr_i), .vid_gnt_o(vid_gnt_o),
        .vid_rvalid_o(vid_rvalid_o), .vid_rdata_o(vid_rdata_o),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_wmask_i(cpu_wmask_i), .cpu_gnt_o(cpu_gnt_o),
        .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
        .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_ready_i(mem_ready_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (updates on each clock edge) ----------------
    cmd_t              cmd_q[$];
    logic              tag_q[$];
    logic [DATA_W-1:0] vid_exp_q[$];
    logic [DATA_W-1:0] cpu_exp_q[$];
    logic              m_busy;
    cmd_t              m_cur;
    int                m_run;
    logic              m_err;

    always @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmd_q.delete(); tag_q.delete(); vid_exp_q.delete(); cpu_exp_q.delete();
            m_busy = 1'b0; m_run = 0; m_err = 1'b0;
        end else begin
            int  n_out;
            bit  v_ok, c_ok, c_wins;
            cmd_t c;
            n_out = tag_q.size();
            if (mem_rvalid_i) begin
                if (n_out == 0) m_err = 1'b1;
                else if (tag_q.pop_front() == 1'b0) vid_exp_q.push_back(mem_rdata_i);
                else cpu_exp_q.push_back(mem_rdata_i);
            end
            if (m_busy) begin
                if (mem_ready_i) begin
                    if (m_cur.src) m_run = 0;
                    else if (m_run < VID_RUN_MAX) m_run = m_run + 1;
                    if (!m_cur.we) tag_q.push_back(m_cur.src);
                    m_busy = 1'b0;
                end
            end else begin
                v_ok   = vid_req_i && (n_out < TAG_DEPTH);
                c_ok   = cpu_req_i && (cpu_we_i || (n_out < TAG_DEPTH));
                c_wins = c_ok && (!v_ok || (m_run == VID_RUN_MAX));
                if (!cpu_req_i) m_run = 0;
                if (c_wins) begin
                    c = '{1'b1, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_wmask_i};
                end else begin
                    c = '{1'b0, 1'b0, vid_addr_i, '0, '0};
                end
                if (c_wins || v_ok) begin
                    cmd_q.push_back(c);
                    m_cur  = c;
                    m_busy = 1'b1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset_n_i) begin
            bit   exp_v, acc;
            cmd_t c;
            exp_v = (cmd_q.size() > 0);
            check("mem_valid", mem_valid_o, exp_v);
            if (exp_v && mem_valid_o) begin
                c   = cmd_q[0];
                acc = mem_ready_i;
                check("mem_we", mem_we_o, c.we);
                check("mem_addr", mem_addr_o, c.addr);
                check("mem_wdata", mem_wdata_o, c.wdata);
                check("mem_wmask", mem_wmask_o, c.wmask);
                check("vid_gnt", vid_gnt_o, acc && !c.src);
                check("cpu_gnt", cpu_gnt_o, acc && c.src);
                if (acc) void'(cmd_q.pop_front());
            end else begin
                check("vid_gnt_idle", vid_gnt_o, 1'b0);
                check("cpu_gnt_idle", cpu_gnt_o, 1'b0);
            end
            check("vid_rvalid", vid_rvalid_o, vid_exp_q.size() > 0);
            if (vid_exp_q.size() > 0) check("vid_rdata", vid_rdata_o, vid_exp_q.pop_front());
            check("cpu_rvalid", cpu_rvalid_o, cpu_exp_q.size() > 0);
            if (cpu_exp_q.size() > 0) check("cpu_rdata", cpu_rdata_o, cpu_exp_q.pop_front());
            check("err", err_o, m_err);
        end
    end

    // ---------------- stimulus ----------------
    int vid_mode = 0;   // 0 none, 1 random, 2 continuous
    int cpu_mode = 0;   // 0 none, 1 random r/w, 2 continuous reads
    int ready_pct = 100;
    int rsp_pct = 100;
    bit rsp_hold = 1'b0;
    int pend = 0;
    int rd_acc = 0;
    int n_cgnt = 0;
    bit gseq[$];
    logic [DATA_W-1:0] rsp_fixed[$];
    logic [DATA_W-1:0] last_vdata, last_cdata;

    task automatic step();
        logic vg, cg, acc_rd;
        @(negedge clk);
        vg = vid_gnt_o;
        cg = cpu_gnt_o;
        acc_rd = mem_valid_o && mem_ready_i && !mem_we_o;
        if (vg) gseq.push_back(1'b0);
        if (cg) begin gseq.push_back(1'b1); n_cgnt++; end
        if (acc_rd) rd_acc++;
        if (vid_rvalid_o) last_vdata = vid_rdata_o;
        if (cpu_rvalid_o) last_cdata = cpu_rdata_o;
        @(posedge clk);
        #1;
        if (acc_rd) pend++;
        if (vg || !vid_req_i) begin
            vid_req_i = 1'b0;
            if (vid_mode == 2 || (vid_mode == 1 && $urandom_range(99) < 40)) begin
                vid_req_i  = 1'b1;
                vid_addr_i = ADDR_W'($urandom());
            end
        end
        if (cg || !cpu_req_i) begin
            cpu_req_i = 1'b0;
            if (cpu_mode == 2 || (cpu_mode == 1 && $urandom_range(99) < 40)) begin
                cpu_req_i   = 1'b1;
                cpu_we_i    = (cpu_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
                cpu_addr_i  = ADDR_W'($urandom());
                cpu_wdata_i = DATA_W'($urandom());
                cpu_wmask_i = MASK_W'($urandom());
            end
        end
        mem_ready_i = ($urandom_range(99) < ready_pct);
        if (pend > 0 && !rsp_hold && $urandom_range(99) < rsp_pct) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = (rsp_fixed.size() > 0) ? rsp_fixed.pop_front() : DATA_W'($urandom());
            pend--;
        end else begin
            mem_rvalid_i = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int base;
        reset_n_i = 1'b0;
        vid_req_i = 1'b0; vid_addr_i = '0;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0; cpu_wmask_i = '0;
        mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        last_vdata = '0; last_cdata = '0;
        #2;
        check("rst_mem_valid", mem_valid_o, 1'b0);
        check("rst_mem_fields", {mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o}, 64'h0);
        check("rst_gnt", {vid_gnt_o, cpu_gnt_o}, 2'b00);
        check("rst_rvalid", {vid_rvalid_o, cpu_rvalid_o}, 2'b00);
        check("rst_rdata", {vid_rdata_o, cpu_rdata_o}, 64'h0);
        check("rst_err", err_o, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset_n_i = 1'b1;
        run(2);

        // CPU write alone: command and grant in the cycle after the request.
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 24'h000100;
        cpu_wdata_i = 32'hDEADBEEF; cpu_wmask_i = 4'hF;
        step();
        check("t1_valid", mem_valid_o, 1'b1);
        check("t1_cmd", {mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o},
              {1'b1, 24'h000100, 32'hDEADBEEF, 4'hF});
        check("t1_gnt", cpu_gnt_o, 1'b1);
        run(4);

        // Read routing with fixed response data.
        rsp_fixed.push_back(32'h11111111);
        rsp_fixed.push_back(32'h22222222);
        vid_req_i = 1'b1; vid_addr_i = 24'h001000;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 24'h002000;
        run(12);
        check("t2_vid_rdata", last_vdata, 32'h11111111);
        check("t2_cpu_rdata", last_cdata, 32'h22222222);

        // Starvation bound: 8 video grants then 1 CPU grant, repeating.
        base = gseq.size();
        vid_mode = 2; cpu_mode = 2;
        run(90);
        vid_mode = 0; cpu_mode = 0;
        run(12);
        check("t3_grant_count", gseq.size() >= base + 27, 1'b1);
        for (int i = 0; i < 27; i++) begin
            check("t3_grant_seq", gseq[base + i], (i % 9) == 8);
        end

        // Tag full: four reads outstanding block the fifth; a CPU write still goes.
        base = rd_acc;
        rsp_hold = 1'b1; vid_mode = 2;
        run(14);
        check("t4_reads_accepted", rd_acc - base, 4);
        check("t4_blocked", mem_valid_o, 1'b0);
        base = n_cgnt;
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 24'h00ABCD;
        cpu_wdata_i = 32'hCAFEF00D; cpu_wmask_i = 4'h5;
        run(4);
        check("t4_cpu_write_gnt", n_cgnt - base, 1);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BADC0DE; pend--;
        step();
        step();
        check("t4_fifth_read", mem_valid_o, 1'b1);
        vid_mode = 0; rsp_hold = 1'b0;
        run(30);

        // Backpressure: command held stable, CPU granted before the late video request.
        base = gseq.size();
        ready_pct = 0;
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 24'h00F00F;
        cpu_wdata_i = 32'h12345678; cpu_wmask_i = 4'h3;
        run(2);
        vid_req_i = 1'b1; vid_addr_i = 24'h0C0C0C;
        run(4);
        ready_pct = 100;
        run(8);
        check("t5_first_cpu", gseq[base], 1'b1);
        check("t5_then_vid", gseq[base + 1], 1'b0);

        // Randomized traffic.
        vid_mode = 1; cpu_mode = 1; ready_pct = 70; rsp_pct = 50;
        run(1500);
        vid_mode = 0; cpu_mode = 0; ready_pct = 100; rsp_pct = 100;
        run(60);
        check("drain_cmd", cmd_q.size(), 0);
        check("drain_tags", tag_q.size(), 0);
        check("drain_pend", pend, 0);

        // Spurious response, then reset while a command is pending.
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF0000;
        step();
        check("t6_err_set", err_o, 1'b1);
        check("t6_no_rvalid", {vid_rvalid_o, cpu_rvalid_o}, 2'b00);
        ready_pct = 0;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 24'h000777;
        run(3);
        check("t6_issue_pending", mem_valid_o, 1'b1);
        reset_n_i = 1'b0;
        #1;
        check("t6_rst_valid", mem_valid_o, 1'b0);
        check("t6_rst_err", err_o, 1'b0);
        check("t6_rst_gnt", cpu_gnt_o, 1'b0);
        cpu_req_i = 1'b0; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; pend = 0;
        repeat (2) @(posedge clk);
        #1 reset_n_i = 1'b1;
        ready_pct = 100;
        run(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
